seed_random_1_card_dealer: RTL and testbench

Consumer side of the seed/random card counter. It drives the counter's run request from the player's deal button and samples the frozen counter value once the request drops. It then maps the value to a playing card, using a dealt-card mask and linear probing so no card is dealt twice per deck. Each card goes to the game FSM over a valid/ready handshake. It sits between the random counter and the blackjack game controller.

---
 rtl/seed_random_1_card_pkg.sv | 25 ++
 rtl/seed_random_1_card_decode.sv | 35 +++
 rtl/seed_random_1_card_dealer.sv | 137 +++++++++++++
 tb/tb_seed_random_1_card_dealer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seed_random_1_card_pkg.sv
// seed_random_1_card_pkg: deck constants, dealer FSM state codes and suit codes
// shared by the card dealer and the index-to-card decoder.
package seed_random_1_card_pkg;

    localparam int RANKS_PER_SUIT = 13;
    localparam int NUM_SUITS      = 4;
    localparam int DECK_SIZE_C    = NUM_SUITS * RANKS_PER_SUIT;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPIN,
        ST_SETTLE,
        ST_CHECK,
        ST_STEP,
        ST_PRESENT
    } state_e;

    typedef enum logic [1:0] {
        SUIT_HEARTS   = 2'd0,
        SUIT_DIAMONDS = 2'd1,
        SUIT_CLUBS    = 2'd2,
        SUIT_SPADES   = 2'd3
    } suit_e;

endpackage

// File: rtl/seed_random_1_card_decode.sv
// seed_random_1_card_decode: combinational card index (1..52) -> rank (1..13) / suit (0..3).
// Divider-free: suit from threshold compares, rank by subtracting the suit's base index.
module seed_random_1_card_decode
    import seed_random_1_card_pkg::*;
(
    input  logic [5:0] idx_i,
    output logic [3:0] rank_o,
    output logic [1:0] suit_o
);

    logic [5:0] card;
    logic [5:0] base;
    suit_e      suit;

    // NOTE: every variable gets a default before the if-chain, so no latch is inferred.
    always_comb begin
        card = idx_i - 6'd1;
        suit = SUIT_HEARTS;
        base = 6'd0;
        if (card >= 6'(3 * RANKS_PER_SUIT)) begin
            suit = SUIT_SPADES;
            base = 6'(3 * RANKS_PER_SUIT);
        end else if (card >= 6'(2 * RANKS_PER_SUIT)) begin
            suit = SUIT_CLUBS;
            base = 6'(2 * RANKS_PER_SUIT);
        end else if (card >= 6'(RANKS_PER_SUIT)) begin
            suit = SUIT_DIAMONDS;
            base = 6'(RANKS_PER_SUIT);
        end
    end

    assign rank_o = 4'(card - base + 6'd1);
    assign suit_o = suit;

endmodule

// File: rtl/seed_random_1_card_dealer.sv
// seed_random_1_card_dealer: spins the random counter while deal is held, then turns the
// frozen value into a card. DEALER_DUP_CHECK_EN enables the dealt mask / finite deck.
module seed_random_1_card_dealer
    import seed_random_1_card_pkg::*;
#(
    parameter int MIN_SPIN  = 4,
    parameter int DECK_SIZE = DECK_SIZE_C
) (
    input  logic       clk_dp_c_i,
    input  logic       rst_dp_c_i,
    input  logic       deal_req_i,
    input  logic       shuffle_i,
    input  logic [7:0] next_card_i,
    output logic       req_card_state_o,
    output logic       card_valid_o,
    input  logic       card_ready_i,
    output logic [3:0] card_rank_o,
    output logic [1:0] card_suit_o,
    output logic [5:0] cards_left_o,
    output logic       deck_empty_o
);

    state_e     state_q;
    logic [3:0] spin_cnt_q;
    logic       req_q;
    logic       valid_q;
    logic [3:0] rank_q;
    logic [1:0] suit_q;

    logic       idx_valid;
    logic       idx_free;
    logic       spin_done;
    logic [3:0] dec_rank;
    logic [1:0] dec_suit;

    seed_random_1_card_decode u_decode (
        .idx_i  (next_card_i[5:0]),
        .rank_o (dec_rank),
        .suit_o (dec_suit)
    );

    assign idx_valid = (next_card_i != 8'd0) && (next_card_i <= 8'(DECK_SIZE));
    // spin_cnt_q counts completed SPIN cycles, so the current one makes it MIN_SPIN.
    assign spin_done = !deal_req_i && (spin_cnt_q >= 4'(MIN_SPIN - 1));

`ifdef DEALER_DUP_CHECK_EN
    logic [DECK_SIZE-1:0] mask_q;
    logic [5:0]           left_q;
    logic [5:0]           slot;

    assign slot         = next_card_i[5:0] - 6'd1;
    assign idx_free     = idx_valid && !mask_q[slot];
    assign cards_left_o = left_q;
    assign deck_empty_o = (left_q == 6'd0);
`else
    logic unused_shuffle;

    assign unused_shuffle = shuffle_i;
    assign idx_free       = idx_valid;
    assign cards_left_o   = 6'(DECK_SIZE);
    assign deck_empty_o   = 1'b0;
`endif

    // NOTE: all state, including the dealt mask, is cleared by the async reset and
    // updated with non-blocking assignments only.
    always_ff @(posedge clk_dp_c_i or negedge rst_dp_c_i) begin
        if (!rst_dp_c_i) begin
            state_q    <= ST_IDLE;
            spin_cnt_q <= 4'd0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            rank_q     <= 4'd0;
            suit_q     <= 2'd0;
`ifdef DEALER_DUP_CHECK_EN
            mask_q     <= '0;
            left_q     <= 6'(DECK_SIZE);
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
`ifdef DEALER_DUP_CHECK_EN
                    if (shuffle_i) begin
                        mask_q <= '0;
                        left_q <= 6'(DECK_SIZE);
                    end else
`endif
                    if (deal_req_i && !deck_empty_o) begin
                        state_q    <= ST_SPIN;
                        req_q      <= 1'b1;
                        spin_cnt_q <= 4'd0;
                    end
                end
                ST_SPIN: begin
                    if (spin_done) begin
                        state_q <= ST_SETTLE;
                        req_q   <= 1'b0;
                    end else if (spin_cnt_q != 4'hF) begin
                        spin_cnt_q <= spin_cnt_q + 4'd1;
                    end
                end
                ST_SETTLE: state_q <= ST_CHECK;
                ST_CHECK: begin
                    if (!idx_free) begin
                        state_q <= ST_STEP;
                        req_q   <= 1'b1;
                    end else begin
                        state_q <= ST_PRESENT;
                        valid_q <= 1'b1;
                        rank_q  <= dec_rank;
                        suit_q  <= dec_suit;
`ifdef DEALER_DUP_CHECK_EN
                        mask_q[slot] <= 1'b1;
                        left_q       <= left_q - 6'd1;
`endif
                    end
                end
                ST_STEP: begin
                    state_q <= ST_SETTLE;
                    req_q   <= 1'b0;
                end
                ST_PRESENT: begin
                    if (card_ready_i) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_card_state_o = req_q;
    assign card_valid_o     = valid_q;
    assign card_rank_o      = rank_q;
    assign card_suit_o      = suit_q;

endmodule

// File: tb/tb_seed_random_1_card_dealer.sv
// tb_seed_random_1_card_dealer: directed tests of the card dealer against a behavioural
// model of the random counter that advances while req_card_state_o is high.
module tb_seed_random_1_card_dealer;

`ifdef DEALER_DUP_CHECK_EN
    localparam int LEFT_STEP = 1;
`else
    localparam int LEFT_STEP = 0;
`endif

    logic       clk_dp_c_i   = 1'b0;
    logic       rst_dp_c_i   = 1'b0;
    logic       deal_req_i   = 1'b0;
    logic       shuffle_i    = 1'b0;
    logic       card_ready_i = 1'b0;
    logic [7:0] next_card_i;
    logic       req_card_state_o;
    logic       card_valid_o;
    logic [3:0] card_rank_o;
    logic [1:0] card_suit_o;
    logic [5:0] cards_left_o;
    logic       deck_empty_o;

    int checks   = 0;
    int failures = 0;
    int req_hi;
    int lat;
    int n_dealt  = 0;
    bit seen [64];

    logic [7:0] cnt_q;
    logic       cnt_load     = 1'b0;
    logic [7:0] cnt_load_val = 8'd0;

    seed_random_1_card_dealer #(.MIN_SPIN(4), .DECK_SIZE(52)) dut (
        .clk_dp_c_i       (clk_dp_c_i),
        .rst_dp_c_i       (rst_dp_c_i),
        .deal_req_i       (deal_req_i),
        .shuffle_i        (shuffle_i),
        .next_card_i      (next_card_i),
        .req_card_state_o (req_card_state_o),
        .card_valid_o     (card_valid_o),
        .card_ready_i     (card_ready_i),
        .card_rank_o      (card_rank_o),
        .card_suit_o      (card_suit_o),
        .cards_left_o     (cards_left_o),
        .deck_empty_o     (deck_empty_o)
    );

    always #5 clk_dp_c_i = ~clk_dp_c_i;

    // Counter model: registered, +1 mod 53 per cycle of request, loadable by the bench.
    always_ff @(posedge clk_dp_c_i or negedge rst_dp_c_i) begin
        if (!rst_dp_c_i)            cnt_q <= 8'd0;
        else if (cnt_load)          cnt_q <= cnt_load_val;
        else if (req_card_state_o)  cnt_q <= (cnt_q == 8'd52) ? 8'd0 : cnt_q + 8'd1;
    end
    assign next_card_i = cnt_q;

    task automatic load_counter(input logic [7:0] v);
        @(negedge clk_dp_c_i);
        cnt_load     = 1'b1;
        cnt_load_val = v;
        @(negedge clk_dp_c_i);
        cnt_load     = 1'b0;
    endtask

    // Holds deal_req_i for 'hold' cycles; req_hi = request-high cycles seen, lat = cycles
    // from the first low deal_req_i cycle to card_valid_o (-1 if it never came).
    task automatic deal(input int hold);
        req_hi = 0;
        lat    = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_dp_c_i);
            if (card_valid_o) begin
                lat = i - hold;
                break;
            end
            if (req_card_state_o) req_hi++;
            deal_req_i = (i < hold);
        end
        deal_req_i = 1'b0;
    endtask

    task automatic accept();
        seen[int'(card_suit_o) * 13 + int'(card_rank_o)] = 1'b1;
        n_dealt++;
        card_ready_i = 1'b1;
        @(negedge clk_dp_c_i);
        card_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_dp_c_i = 1'b0;
        repeat (2) @(negedge clk_dp_c_i);
        checks++; if (req_card_state_o !== 1'b0) begin failures++; $display("FAIL reset_req: got %0b want 0", req_card_state_o); end
        checks++; if (card_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b want 0", card_valid_o); end
        checks++; if (card_rank_o !== 4'd0 || card_suit_o !== 2'd0) begin failures++; $display("FAIL reset_card: got rank %0d suit %0d want 0 0", card_rank_o, card_suit_o); end
        checks++; if (cards_left_o !== 6'd52 || deck_empty_o !== 1'b0) begin failures++; $display("FAIL reset_left: got %0d empty %0b want 52 0", cards_left_o, deck_empty_o); end
        rst_dp_c_i = 1'b1;
    endtask

    task automatic test_basic_deal();
        deal(6);
        checks++; if (req_hi !== 6 || lat !== 3) begin failures++; $display("FAIL basic_timing: got req %0d lat %0d want 6 3", req_hi, lat); end
        checks++; if (card_rank_o !== 4'd6 || card_suit_o !== 2'd0) begin failures++; $display("FAIL basic_card: got rank %0d suit %0d want 6 0", card_rank_o, card_suit_o); end
        accept();
        checks++; if (card_valid_o !== 1'b0) begin failures++; $display("FAIL basic_accept: got valid %0b want 0", card_valid_o); end
        checks++; if (cards_left_o !== 6'(52 - n_dealt * LEFT_STEP)) begin failures++; $display("FAIL basic_left: got %0d want %0d", cards_left_o, 52 - n_dealt * LEFT_STEP); end
    endtask

    task automatic test_short_press();
        load_counter(8'd0);
        deal(1);
        checks++; if (req_hi !== 4 || lat !== 6) begin failures++; $display("FAIL short_timing: got req %0d lat %0d want 4 6", req_hi, lat); end
        checks++; if (card_rank_o !== 4'd4 || card_suit_o !== 2'd0) begin failures++; $display("FAIL short_card: got rank %0d suit %0d want 4 0", card_rank_o, card_suit_o); end
        accept();
    endtask

    task automatic test_duplicate_probe();
        int exp_req, exp_lat, exp_rank;
`ifdef DEALER_DUP_CHECK_EN
        exp_req = 5; exp_lat = 6; exp_rank = 7;
`else
        exp_req = 4; exp_lat = 3; exp_rank = 6;
`endif
        load_counter(8'd2);
        deal(4);
        checks++; if (req_hi !== exp_req || lat !== exp_lat) begin failures++; $display("FAIL dup_timing: got req %0d lat %0d want %0d %0d", req_hi, lat, exp_req, exp_lat); end
        checks++; if (card_rank_o !== 4'(exp_rank) || card_suit_o !== 2'd0) begin failures++; $display("FAIL dup_card: got rank %0d suit %0d want %0d 0", card_rank_o, card_suit_o, exp_rank); end
        accept();
    endtask

    task automatic test_wrap_zero();
        int exp_req, exp_lat;
        load_counter(8'd48);
        deal(4);
        checks++; if (card_rank_o !== 4'd13 || card_suit_o !== 2'd3 || lat !== 3) begin failures++; $display("FAIL wrap_52: got rank %0d suit %0d lat %0d want 13 3 3", card_rank_o, card_suit_o, lat); end
        accept();
`ifdef DEALER_DUP_CHECK_EN
        exp_req = 6; exp_lat = 9;
        load_counter(8'd48);
`else
        exp_req = 5; exp_lat = 6;
        load_counter(8'd49);
`endif
        deal(4);
        checks++; if (req_hi !== exp_req || lat !== exp_lat) begin failures++; $display("FAIL wrap_timing: got req %0d lat %0d want %0d %0d", req_hi, lat, exp_req, exp_lat); end
        checks++; if (card_rank_o !== 4'd1 || card_suit_o !== 2'd0) begin failures++; $display("FAIL wrap_ace: got rank %0d suit %0d want 1 0", card_rank_o, card_suit_o); end
        accept();
        load_counter(8'd36);
        deal(4);
        checks++; if (card_rank_o !== 4'd1 || card_suit_o !== 2'd3) begin failures++; $display("FAIL map_40: got rank %0d suit %0d want 1 3", card_rank_o, card_suit_o); end
        accept();
    endtask

    task automatic test_mapping();
        int idx_t  [5] = '{13, 14, 26, 27, 39};
        int rank_t [5] = '{13,  1, 13,  1, 13};
        int suit_t [5] = '{ 0,  1,  1,  2,  2};
        for (int k = 0; k < 5; k++) begin
            load_counter(8'(idx_t[k] - 4));
            deal(4);
            checks++;
            if (card_rank_o !== 4'(rank_t[k]) || card_suit_o !== 2'(suit_t[k]) || lat !== 3) begin
                failures++;
                $display("FAIL map_%0d: got rank %0d suit %0d lat %0d want %0d %0d 3", idx_t[k], card_rank_o, card_suit_o, lat, rank_t[k], suit_t[k]);
            end
            accept();
        end
    endtask

    task automatic test_backpressure();
        load_counter(8'd16);
        deal(4);
        for (int k = 0; k < 10; k++) begin
            deal_req_i = k[0];
            @(negedge clk_dp_c_i);
            checks++;
            if (card_valid_o !== 1'b1 || card_rank_o !== 4'd7 || card_suit_o !== 2'd1 || req_card_state_o !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold_%0d: got valid %0b rank %0d suit %0d req %0b want 1 7 1 0", k, card_valid_o, card_rank_o, card_suit_o, req_card_state_o);
            end
        end
        deal_req_i = 1'b0;
        accept();
        checks++; if (card_valid_o !== 1'b0) begin failures++; $display("FAIL bp_accept: got valid %0b want 0", card_valid_o); end
        @(negedge clk_dp_c_i);
        checks++; if (req_card_state_o !== 1'b0 || cnt_q !== 8'd20) begin failures++; $display("FAIL bp_ignored: got req %0b counter %0d want 0 20", req_card_state_o, cnt_q); end
        checks++; if (cards_left_o !== 6'(52 - n_dealt * LEFT_STEP)) begin failures++; $display("FAIL bp_left: got %0d want %0d", cards_left_o, 52 - n_dealt * LEFT_STEP); end
    endtask

    task automatic test_empty_shuffle();
`ifdef DEALER_DUP_CHECK_EN
        int idx;
        for (int d = 0; d < 60 && cards_left_o != 6'd0; d++) begin
            deal(4);
            idx = int'(card_suit_o) * 13 + int'(card_rank_o);
            checks++; if (lat < 3 || seen[idx]) begin failures++; $display("FAIL empty_deal_%0d: got idx %0d lat %0d seen %0b want fresh", d, idx, lat, seen[idx]); end
            accept();
            checks++; if (cards_left_o !== 6'(52 - n_dealt)) begin failures++; $display("FAIL empty_left_%0d: got %0d want %0d", d, cards_left_o, 52 - n_dealt); end
        end
        checks++; if (cards_left_o !== 6'd0 || deck_empty_o !== 1'b1) begin failures++; $display("FAIL empty_flag: got %0d empty %0b want 0 1", cards_left_o, deck_empty_o); end
        deal_req_i = 1'b1;
        repeat (6) begin
            @(negedge clk_dp_c_i);
            checks++; if (req_card_state_o !== 1'b0) begin failures++; $display("FAIL empty_ignore: got req %0b want 0", req_card_state_o); end
        end
        shuffle_i = 1'b1;
        @(negedge clk_dp_c_i);
        shuffle_i  = 1'b0;
        deal_req_i = 1'b0;
        checks++; if (cards_left_o !== 6'd52 || deck_empty_o !== 1'b0 || req_card_state_o !== 1'b0) begin failures++; $display("FAIL shuffle: got left %0d empty %0b req %0b want 52 0 0", cards_left_o, deck_empty_o, req_card_state_o); end
`else
        checks++; if (cards_left_o !== 6'd52 || deck_empty_o !== 1'b0) begin failures++; $display("FAIL inf_left: got %0d empty %0b want 52 0", cards_left_o, deck_empty_o); end
        shuffle_i = 1'b1;
        @(negedge clk_dp_c_i);
        shuffle_i = 1'b0;
        checks++; if (cards_left_o !== 6'd52 || req_card_state_o !== 1'b0) begin failures++; $display("FAIL inf_shuffle: got left %0d req %0b want 52 0", cards_left_o, req_card_state_o); end
`endif
        foreach (seen[k]) seen[k] = 1'b0;
        n_dealt = 0;
    endtask

    task automatic test_reset_mid_spin();
        load_counter(8'd0);
        deal(4);
        accept();
        checks++; if (cards_left_o !== 6'(52 - LEFT_STEP)) begin failures++; $display("FAIL pre_reset_left: got %0d want %0d", cards_left_o, 52 - LEFT_STEP); end
        @(negedge clk_dp_c_i);
        deal_req_i = 1'b1;
        repeat (2) @(negedge clk_dp_c_i);
        checks++; if (req_card_state_o !== 1'b1) begin failures++; $display("FAIL spin_req: got %0b want 1", req_card_state_o); end
        rst_dp_c_i = 1'b0;
        @(negedge clk_dp_c_i);
        checks++;
        if (req_card_state_o !== 1'b0 || card_valid_o !== 1'b0 || card_rank_o !== 4'd0 || card_suit_o !== 2'd0 || cards_left_o !== 6'd52 || deck_empty_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: got req %0b valid %0b rank %0d suit %0d left %0d empty %0b want 0 0 0 0 52 0", req_card_state_o, card_valid_o, card_rank_o, card_suit_o, cards_left_o, deck_empty_o);
        end
        deal_req_i = 1'b0;
        rst_dp_c_i = 1'b1;
        n_dealt    = 0;
        deal(4);
        checks++; if (card_rank_o !== 4'd4 || card_suit_o !== 2'd0 || lat !== 3) begin failures++; $display("FAIL post_reset_deal: got rank %0d suit %0d lat %0d want 4 0 3", card_rank_o, card_suit_o, lat); end
        accept();
    endtask

    initial begin
        test_reset();
        test_basic_deal();
        test_short_press();
        test_duplicate_probe();
        test_wrap_zero();
        test_mapping();
        test_backpressure();
        test_empty_shuffle();
        test_reset_mid_spin();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
